pipelined_riscv_hazard_unit: RTL and testbench
==============================================

Name: pipelined_riscv_hazard_unit

Overview:
- Hazard and forwarding controller for the 5-stage pipelined RV64 core (F/D/E/M/W).
- Holds its own shadow copy of the E, M and W instruction metadata. The copy advances in lock-step with the pipeline registers.
- From that copy it drives stall, flush and E-stage operand-forward selects. Covered hazards: RAW, load-use (configurable latency), taken-branch and multi-cycle memory wait.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_LATENCY, 1, bubbles inserted between a load and a dependent instruction. Legal values are 1 and 2.
- CNT_W, 32, stall counter width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- rs1_d  in  REG_ADDR_W  D-stage source 1
- rs2_d  in  REG_ADDR_W  D-stage source 2
- rs1_used_d  in  1  D instruction reads rs1
- rs2_used_d  in  1  D instruction reads rs2
- rd_d  in  REG_ADDR_W  D-stage destination
- reg_write_d  in  1  D instruction writes rd
- result_src_d  in  2  00 ALU, 01 load, 10 pc+4
- mem_access_d  in  1  D instruction is a load or store
- pc_source_e  in  1  taken branch/jump resolved in E
- mem_ready  in  1  data memory completes the access held in M
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- stall_e  out  1  hold D/E register
- stall_m  out  1  hold E/M and M/W registers
- flush_d  out  1  clear F/D register
- flush_e  out  1  insert bubble into D/E register
- forward_a_e  out  2  E operand A select: 00 regfile, 01 W result, 10 M alu_result, 11 M pc+4
- forward_b_e  out  2  same encoding as forward_a_e, for operand B
- stall_cycles  out  CNT_W  saturating count of cycles with stall_f=1
- state  out  2  00 RUN, 01 LOAD_STALL, 10 MEM_WAIT

Behaviour:
- Shadow entries E, M, W each hold: valid, rs1, rs2, rd, reg_write, result_src, mem_access.
- Reset (reset_n=0 at a rising edge):
  - All shadow entries become invalid, state=RUN, stall_cycles=0.
  - Every stall, flush and forward output reads 0.
  - Reset applied mid-stall or mid-MEM_WAIT returns to RUN on the next edge.
- Condition definitions:
  - match(x, e): e is valid, e.reg_write=1, e.rd!=0, e.rd==x.
  - mem_wait: M is valid, M.mem_access=1, mem_ready=0.
  - load_hz: any stage k < LOAD_LATENCY (k=0 is E, k=1 is M) holds a load (result_src=01) with match against (rs1_d and rs1_used_d) or (rs2_d and rs2_used_d).
- Priority: mem_wait > pc_source_e > load_hz > RUN.
- MEM_WAIT:
  - stall_f=stall_d=stall_e=stall_m=1, no flushes, shadow frozen.
  - pc_source_e stays asserted by the frozen E stage and is honoured on the first cycle after mem_ready.
- Branch (pc_source_e=1, no mem_wait):
  - flush_d=1, flush_e=1, no stalls; any pending load_hz is cancelled.
  - Shadow: E<=bubble, M<=E, W<=M.
- LOAD_STALL (load_hz, no branch, no mem_wait):
  - stall_f=stall_d=1, flush_e=1.
  - Shadow: E<=bubble, M<=E, W<=M.
  - Re-evaluated every cycle, so total bubbles equal LOAD_LATENCY.
- RUN:
  - All stalls and flushes 0.
  - Shadow: E<=D inputs (valid=1), M<=E, W<=M.
- state output reflects the condition active in the current cycle (combinational from the priority decode).
- Forwarding, evaluated per operand for E.rs1 (A) and E.rs2 (B); the first true rule wins:
  1. match(rs, M) with M.result_src=00 gives 10.
  2. match(rs, M) with M.result_src=10 gives 11.
  3. match(rs, W) with W.result_src!=01, or with W.result_src=01 and LOAD_LATENCY=1, gives 01.
  4. Otherwise 00.
- A matching load in M never reaches forwarding: load_hz prevents it.
- x0 is never forwarded or stalled on.
- The register file is write-through (write on falling edge), so no forwarding from beyond W.
- Forward selects are held constant during MEM_WAIT.
- stall_cycles increments on every edge where stall_f=1 and reset_n=1, and saturates at 2^CNT_W-1.

Test Plan:
1. add x5,x1,x2 then sub x6,x5,x3 -> forward_a_e=10 in the sub E cycle. With one independent instruction between them -> forward_a_e=01.
2. ld x7,0(x1) then add x8,x7,x2, LOAD_LATENCY=1 -> exactly one cycle of stall_f=stall_d=flush_e=1, then forward_a_e=01. Same with LOAD_LATENCY=2 -> two stall cycles, forward 00. stall_cycles ends at 1 and 2 respectively.
3. jal x1 followed by a use of x1 -> forward_a_e=11. A taken beq (pc_source_e=1) -> flush_d=flush_e=1 for one cycle with no stall, and the younger load_hz is dropped.
4. Store in M with mem_ready=0 for 3 cycles -> all four stalls high for 3 cycles and state=10. The pc_source_e raised during the wait is acted on in the cycle after mem_ready=1.
5. Writes to and reads of x0 in every pattern above -> forward 00 and no stall. reset_n=0 during LOAD_STALL -> next cycle all outputs 0 and state=00.
6. CNT_W=4 with continuous load-use -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipelined_riscv_hazard_unit_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard/forwarding controller.
// The pipeline side is the master; the hazard unit is the slave.
interface pipelined_riscv_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic                  rs1_used_d;
    logic                  rs2_used_d;
    logic [REG_ADDR_W-1:0] rd_d;
    logic                  reg_write_d;
    logic [1:0]            result_src_d;
    logic                  mem_access_d;
    logic                  pc_source_e;
    logic                  mem_ready;
    logic                  stall_f;
    logic                  stall_d;
    logic                  stall_e;
    logic                  stall_m;
    logic                  flush_d;
    logic                  flush_e;
    logic [1:0]            forward_a_e;
    logic [1:0]            forward_b_e;
    logic [CNT_W-1:0]      stall_cycles;
    logic [1:0]            state;

    modport master (
        output rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d,
               result_src_d, mem_access_d, pc_source_e, mem_ready,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               forward_a_e, forward_b_e, stall_cycles, state
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d,
               result_src_d, mem_access_d, pc_source_e, mem_ready,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               forward_a_e, forward_b_e, stall_cycles, state
    );
endinterface

// File: rtl/pipelined_riscv_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage RV64 pipeline. A shadow copy of the
// E/M/W metadata drives stalls, flushes and E-stage forward selects.
module pipelined_riscv_hazard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 32
) (
    input logic                          clock,
    input logic                          reset_n,
    pipelined_riscv_hazard_unit_if.slave hz
);
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_access;
    } entry_t;

    localparam entry_t BUBBLE = entry_t'({$bits(entry_t){1'b0}});
    localparam logic   CHECK_M_LOAD = (LOAD_LATENCY > 32'sd1);
    localparam logic   W_LOAD_FWD   = (LOAD_LATENCY == 32'sd1);

    entry_t           e_r, m_r, w_r, d_s;
    hz_state_t        state_s;
    logic             mem_wait_s, load_hz_s, bubble_s;
    logic             stall_fd_s, stall_em_s, flush_d_s, flush_e_s;
    logic [1:0]       fwd_a_s, fwd_b_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             w_unused_s;

    function automatic logic match_f(input logic [REG_ADDR_W-1:0] x, input entry_t e);
        return e.valid && e.reg_write && (e.rd != {REG_ADDR_W{1'b0}}) && (e.rd == x);
    endfunction

    function automatic logic load_dep_f(input entry_t e,
                                        input logic [REG_ADDR_W-1:0] rs1, input logic used1,
                                        input logic [REG_ADDR_W-1:0] rs2, input logic used2);
        return (e.result_src == 2'b01) && ((used1 && match_f(rs1, e)) || (used2 && match_f(rs2, e)));
    endfunction

    // A load sitting in M never reaches here because load_hz holds its consumer in D.
    function automatic logic [1:0] fwd_sel_f(input logic [REG_ADDR_W-1:0] rs,
                                             input entry_t m, input entry_t w);
        logic [1:0] sel;
        if (match_f(rs, m) && (m.result_src == 2'b00)) begin
            sel = 2'b10;
        end else if (match_f(rs, m) && (m.result_src == 2'b10)) begin
            sel = 2'b11;
        end else if (match_f(rs, w) && ((w.result_src != 2'b01) || W_LOAD_FWD)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign mem_wait_s = m_r.valid && m_r.mem_access && !hz.mem_ready;
    assign load_hz_s  = load_dep_f(e_r, hz.rs1_d, hz.rs1_used_d, hz.rs2_d, hz.rs2_used_d) ||
                        (CHECK_M_LOAD &&
                         load_dep_f(m_r, hz.rs1_d, hz.rs1_used_d, hz.rs2_d, hz.rs2_used_d));
    assign w_unused_s = ^{w_r.rs1, w_r.rs2, w_r.mem_access};

    // Capture the D-stage instruction as a candidate E entry
    always_comb begin
        d_s            = BUBBLE;
        d_s.valid      = 1'b1;
        d_s.rs1        = hz.rs1_d;
        d_s.rs2        = hz.rs2_d;
        d_s.rd         = hz.rd_d;
        d_s.reg_write  = hz.reg_write_d;
        d_s.result_src = hz.result_src_d;
        d_s.mem_access = hz.mem_access_d;
    end

    // Priority decode: memory wait, then taken branch, then load-use, else run
    always_comb begin
        state_s    = RUN;
        stall_fd_s = 1'b0;
        stall_em_s = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        bubble_s   = 1'b0;
        if (mem_wait_s) begin
            state_s    = MEM_WAIT;
            stall_fd_s = 1'b1;
            stall_em_s = 1'b1;
        end else if (hz.pc_source_e) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
            bubble_s  = 1'b1;
        end else if (load_hz_s) begin
            state_s    = LOAD_STALL;
            stall_fd_s = 1'b1;
            flush_e_s  = 1'b1;
            bubble_s   = 1'b1;
        end else begin
            state_s = RUN;
        end
    end

    // Forward selects come from the frozen shadow during a wait, so they hold steady
    always_comb begin
        fwd_a_s = fwd_sel_f(e_r.rs1, m_r, w_r);
        fwd_b_s = fwd_sel_f(e_r.rs2, m_r, w_r);
    end

    // Shadow pipeline advances with the real pipeline registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            e_r <= BUBBLE;
            m_r <= BUBBLE;
            w_r <= BUBBLE;
        end else if (mem_wait_s) begin
            e_r <= e_r;
            m_r <= m_r;
            w_r <= w_r;
        end else begin
            e_r <= bubble_s ? BUBBLE : d_s;
            m_r <= e_r;
            w_r <= m_r;
        end
    end

    // Saturating count of cycles in which fetch is held
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_fd_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign hz.stall_f      = stall_fd_s;
    assign hz.stall_d      = stall_fd_s;
    assign hz.stall_e      = stall_em_s;
    assign hz.stall_m      = stall_em_s;
    assign hz.flush_d      = flush_d_s;
    assign hz.flush_e      = flush_e_s;
    assign hz.forward_a_e  = fwd_a_s;
    assign hz.forward_b_e  = fwd_b_s;
    assign hz.stall_cycles = stall_cnt_r;
    assign hz.state        = state_s;
endmodule

// File: tb/tb_pipelined_riscv_hazard_unit.sv
// Bench for the hazard unit: three instances (load latency 1, load latency 2, 4-bit counter)
// share one stimulus stream and are checked against a behavioural pipeline model.
module tb_pipelined_riscv_hazard_unit;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] rs1_d = 5'd0, rs2_d = 5'd0, rd_d = 5'd0;
    logic       rs1_used_d = 1'b0, rs2_used_d = 1'b0, reg_write_d = 1'b0, mem_access_d = 1'b0;
    logic [1:0] result_src_d = 2'd0;
    logic       pc_source_e = 1'b0, mem_ready = 1'b1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    pipelined_riscv_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) if0 ();
    pipelined_riscv_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) if1 ();
    pipelined_riscv_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(4))  if2 ();

    pipelined_riscv_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(32))
        u0 (.clock(clock), .reset_n(reset_n), .hz(if0));
    pipelined_riscv_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(2), .CNT_W(32))
        u1 (.clock(clock), .reset_n(reset_n), .hz(if1));
    pipelined_riscv_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(4))
        u2 (.clock(clock), .reset_n(reset_n), .hz(if2));

    assign {if0.rs1_d, if0.rs2_d, if0.rs1_used_d, if0.rs2_used_d, if0.rd_d, if0.reg_write_d,
            if0.result_src_d, if0.mem_access_d, if0.pc_source_e, if0.mem_ready} =
           {rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d, result_src_d, mem_access_d,
            pc_source_e, mem_ready};
    assign {if1.rs1_d, if1.rs2_d, if1.rs1_used_d, if1.rs2_used_d, if1.rd_d, if1.reg_write_d,
            if1.result_src_d, if1.mem_access_d, if1.pc_source_e, if1.mem_ready} =
           {rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d, result_src_d, mem_access_d,
            pc_source_e, mem_ready};
    assign {if2.rs1_d, if2.rs2_d, if2.rs1_used_d, if2.rs2_used_d, if2.rd_d, if2.reg_write_d,
            if2.result_src_d, if2.mem_access_d, if2.pc_source_e, if2.mem_ready} =
           {rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d, result_src_d, mem_access_d,
            pc_source_e, mem_ready};

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_a, fwd_b, state}
    logic [11:0] dv [3];
    logic [31:0] dc [3];
    assign dv[0] = {if0.stall_f, if0.stall_d, if0.stall_e, if0.stall_m, if0.flush_d, if0.flush_e,
                    if0.forward_a_e, if0.forward_b_e, if0.state};
    assign dv[1] = {if1.stall_f, if1.stall_d, if1.stall_e, if1.stall_m, if1.flush_d, if1.flush_e,
                    if1.forward_a_e, if1.forward_b_e, if1.state};
    assign dv[2] = {if2.stall_f, if2.stall_d, if2.stall_e, if2.stall_m, if2.flush_d, if2.flush_e,
                    if2.forward_a_e, if2.forward_b_e, if2.state};
    assign dc[0] = if0.stall_cycles;
    assign dc[1] = if1.stall_cycles;
    assign dc[2] = {28'd0, if2.stall_cycles};

    localparam bit [11:0] E0    = 12'b000000_00_00_00;
    localparam bit [11:0] FWA10 = 12'b000000_10_00_00;
    localparam bit [11:0] FWA01 = 12'b000000_01_00_00;
    localparam bit [11:0] FWA11 = 12'b000000_11_00_00;
    localparam bit [11:0] LDST  = 12'b110001_00_00_01;
    localparam bit [11:0] BR    = 12'b000011_00_00_00;
    localparam bit [11:0] MW    = 12'b111100_00_00_10;

    // Behavioural model: an in-flight instruction list per instance, index 0=E, 1=M, 2=W
    typedef struct {
        bit v;
        int rs1, rs2, rd;
        bit wr;
        int src;
        bit mem;
    } ins_t;

    ins_t      pipe [3][3];
    longint    cnt  [3];
    int        lat  [3] = '{1, 2, 1};
    int        cw   [3] = '{32, 32, 4};
    bit [11:0] mexp [3];
    int        mode [3];   // 0 hold, 1 bubble into E, 2 take D into E

    function automatic bit writes(ins_t p, int r);
        return p.v && p.wr && (p.rd != 0) && (p.rd == r);
    endfunction

    function automatic int fwd(int i, int r);
        if (writes(pipe[i][1], r) && pipe[i][1].src == 0) return 2;
        if (writes(pipe[i][1], r) && pipe[i][1].src == 2) return 3;
        if (writes(pipe[i][2], r) && (pipe[i][2].src != 1 || lat[i] == 1)) return 1;
        return 0;
    endfunction

    task automatic model_eval(int i);
        bit wt, ld;
        bit [5:0] ctl;
        int st;
        wt = pipe[i][1].v && pipe[i][1].mem && !mem_ready;
        ld = 1'b0;
        for (int k = 0; k < lat[i]; k++)
            if (pipe[i][k].src == 1 && ((rs1_used_d && writes(pipe[i][k], rs1_d)) ||
                                        (rs2_used_d && writes(pipe[i][k], rs2_d))))
                ld = 1'b1;
        if (wt)               begin ctl = 6'b111100; st = 2; mode[i] = 0; end
        else if (pc_source_e) begin ctl = 6'b000011; st = 0; mode[i] = 1; end
        else if (ld)          begin ctl = 6'b110001; st = 1; mode[i] = 1; end
        else                  begin ctl = 6'b000000; st = 0; mode[i] = 2; end
        mexp[i] = {ctl, 2'(fwd(i, pipe[i][0].rs1)), 2'(fwd(i, pipe[i][0].rs2)), 2'(st)};
    endtask

    task automatic model_edge(int i);
        ins_t bub;
        ins_t d;
        longint mx;
        bub = '{default: 0};
        d = '{1, int'(rs1_d), int'(rs2_d), int'(rd_d), reg_write_d, int'(result_src_d), mem_access_d};
        mx = (longint'(1) << cw[i]) - 1;
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) pipe[i][k] = bub;
            cnt[i] = 0;
        end else begin
            if (mexp[i][11] && cnt[i] < mx) cnt[i] = cnt[i] + 1;
            if (mode[i] != 0) begin
                pipe[i][2] = pipe[i][1];
                pipe[i][1] = pipe[i][0];
                pipe[i][0] = (mode[i] == 1) ? bub : d;
            end
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic settle_check();
        #1;
        for (int i = 0; i < 3; i++) begin
            model_eval(i);
            if (reset_n) begin
                chk($sformatf("model_outs_dut%0d", i), 64'(dv[i]), 64'(mexp[i]));
                chk($sformatf("model_cnt_dut%0d", i), 64'(dc[i]), 64'(cnt[i]));
            end
        end
    endtask

    task automatic advance();
        @(posedge clock);
        for (int i = 0; i < 3; i++) model_edge(i);
        @(negedge clock);
    endtask

    task automatic set_d(int r1, int r2, bit u1, bit u2, int rd, bit wr, int src, bit mem);
        rs1_d = 5'(r1); rs2_d = 5'(r2); rs1_used_d = u1; rs2_used_d = u2;
        rd_d = 5'(rd); reg_write_d = wr; result_src_d = 2'(src); mem_access_d = mem;
    endtask

    typedef struct {
        bit        rst;
        int        rs1, rs2;
        bit        u1, u2;
        int        rd;
        bit        wr;
        int        src;
        bit        mem, pc, rdy;
        bit [11:0] exp;
        int        cnt;
    } vec_t;

    function automatic vec_t row(bit rst, int rs1, int rs2, bit u1, bit u2, int rd, bit wr,
                                 int src, bit mem, bit pc, bit rdy, bit [11:0] exp, int cnt);
        vec_t r;
        r = '{rst, rs1, rs2, u1, u2, rd, wr, src, mem, pc, rdy, exp, cnt};
        return r;
    endfunction

    vec_t tbl [$];

    initial begin
        // Expected values in the table are for the LOAD_LATENCY=1 instances
        tbl.push_back(row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, E0,    0)); // reset
        tbl.push_back(row(1, 1, 2, 1, 1,  5, 1, 0, 0, 0, 1, E0,    0)); // add x5,x1,x2
        tbl.push_back(row(1, 5, 3, 1, 1,  6, 1, 0, 0, 0, 1, E0,    0)); // sub x6,x5,x3
        tbl.push_back(row(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, FWA10, 0)); // nop: sub in E
        tbl.push_back(row(1, 1, 2, 1, 1,  5, 1, 0, 0, 0, 1, E0,    0)); // add x5
        tbl.push_back(row(1, 4, 4, 1, 1,  9, 1, 0, 0, 0, 1, E0,    0)); // and x9 (independent)
        tbl.push_back(row(1, 5, 3, 1, 1,  6, 1, 0, 0, 0, 1, E0,    0)); // sub x6
        tbl.push_back(row(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, FWA01, 0)); // sub in E, add in W
        tbl.push_back(row(1, 1, 0, 1, 0,  7, 1, 1, 1, 0, 1, E0,    0)); // ld x7
        tbl.push_back(row(1, 7, 2, 1, 1,  8, 1, 0, 0, 0, 1, LDST,  0)); // add x8 load-use
        tbl.push_back(row(1, 7, 2, 1, 1,  8, 1, 0, 0, 0, 1, E0,    1)); // add x8 released
        tbl.push_back(row(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, FWA01, 1)); // load forwarded from W
        tbl.push_back(row(1, 0, 0, 0, 0,  1, 1, 2, 0, 0, 1, E0,    1)); // jal x1
        tbl.push_back(row(1, 1, 2, 1, 1, 10, 1, 0, 0, 0, 1, E0,    1)); // add x10,x1,x2
        tbl.push_back(row(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, FWA11, 1)); // pc+4 forward
        tbl.push_back(row(1, 1, 0, 1, 0,  7, 1, 1, 1, 0, 1, E0,    1)); // ld x7
        tbl.push_back(row(1, 7, 2, 1, 1,  8, 1, 0, 0, 1, 1, BR,    1)); // branch beats load_hz
        tbl.push_back(row(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, E0,    1)); // nop
        tbl.push_back(row(1, 1, 2, 1, 1,  0, 0, 0, 1, 0, 1, E0,    1)); // sd x2,0(x1)
        tbl.push_back(row(1, 4, 4, 1, 1,  0, 0, 0, 0, 0, 1, E0,    1)); // beq x4,x4
        tbl.push_back(row(1, 4, 4, 1, 1, 12, 1, 0, 0, 0, 0, MW,    1)); // store waits
        tbl.push_back(row(1, 4, 4, 1, 1, 12, 1, 0, 0, 1, 0, MW,    2)); // branch raised in wait
        tbl.push_back(row(1, 4, 4, 1, 1, 12, 1, 0, 0, 1, 0, MW,    3));
        tbl.push_back(row(1, 4, 4, 1, 1, 12, 1, 0, 0, 1, 1, BR,    4)); // ready: branch taken
        tbl.push_back(row(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, E0,    4));
        tbl.push_back(row(1, 1, 2, 1, 1,  0, 1, 0, 0, 0, 1, E0,    4)); // add x0,x1,x2
        tbl.push_back(row(1, 0, 0, 1, 1, 13, 1, 0, 0, 0, 1, E0,    4)); // add x13,x0,x0
        tbl.push_back(row(1, 1, 0, 1, 0,  0, 1, 1, 1, 0, 1, E0,    4)); // ld x0
        tbl.push_back(row(1, 0, 0, 1, 1, 14, 1, 0, 0, 0, 1, E0,    4)); // use x0 after ld x0
        tbl.push_back(row(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, E0,    4));
        tbl.push_back(row(1, 1, 0, 1, 0,  7, 1, 1, 1, 0, 1, E0,    4)); // ld x7
        tbl.push_back(row(0, 7, 2, 1, 1,  8, 1, 0, 0, 0, 1, E0,    0)); // reset during load stall
        tbl.push_back(row(1, 7, 2, 1, 1,  8, 1, 0, 0, 0, 1, E0,    0)); // all clear after reset
        tbl.push_back(row(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, E0,    0));

        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            for (int k = 0; k < 3; k++) pipe[i][k] = '{default: 0};
        end
        @(negedge clock);

        foreach (tbl[n]) begin
            reset_n = tbl[n].rst;
            pc_source_e = tbl[n].pc;
            mem_ready = tbl[n].rdy;
            set_d(tbl[n].rs1, tbl[n].rs2, tbl[n].u1, tbl[n].u2, tbl[n].rd, tbl[n].wr,
                  tbl[n].src, tbl[n].mem);
            settle_check();
            if (tbl[n].rst) begin
                chk($sformatf("tbl%0d_outs_lat1", n), 64'(dv[0]), 64'(tbl[n].exp));
                chk($sformatf("tbl%0d_outs_cnt4", n), 64'(dv[2]), 64'(tbl[n].exp));
                chk($sformatf("tbl%0d_cnt_lat1", n), 64'(dc[0]), 64'(tbl[n].cnt));
            end
            advance();
        end

        // Load-use with LOAD_LATENCY=2: two bubbles, then no forward
        reset_n = 1'b0; set_d(0, 0, 0, 0, 0, 0, 0, 0); settle_check(); advance();
        reset_n = 1'b1;
        set_d(1, 0, 1, 0, 7, 1, 1, 1); settle_check();
        chk("lat2_ld", 64'(dv[1]), 64'(E0)); advance();
        set_d(7, 2, 1, 1, 8, 1, 0, 0); settle_check();
        chk("lat2_stall1", 64'(dv[1]), 64'(LDST)); advance();
        settle_check();
        chk("lat2_stall2", 64'(dv[1]), 64'(LDST)); advance();
        settle_check();
        chk("lat2_release", 64'(dv[1]), 64'(E0)); advance();
        set_d(0, 0, 0, 0, 0, 0, 0, 0); settle_check();
        chk("lat2_fwd_none", 64'(dv[1]), 64'(E0));
        chk("lat2_cnt", 64'(dc[1]), 64'd2);
        chk("lat1_cnt", 64'(dc[0]), 64'd1);
        advance();

        // Continuous load-use: 20 stalls saturate the 4-bit counter at 15
        reset_n = 1'b0; settle_check(); advance();
        reset_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            set_d(1, 0, 1, 0, 7, 1, 1, 1); settle_check(); advance();
            set_d(7, 2, 1, 1, 8, 1, 0, 0); settle_check(); advance();
            settle_check(); advance();
        end
        set_d(0, 0, 0, 0, 0, 0, 0, 0); settle_check();
        chk("sat_cnt4", 64'(dc[2]), 64'd15);
        chk("sat_cnt32", 64'(dc[0]), 64'd20);
        advance();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            pc_source_e = ($urandom_range(0, 5) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            set_d($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0));
            settle_check();
            advance();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
